// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fft_pkg
// Brief    : Shared types and constants for the 8-point FFT demo.
// Revision : 1.0
// ============================================================================
package fft_pkg;

    localparam int DW = 16;

    typedef enum logic [2:0] {
        LOAD = 3'd0,
        ST1  = 3'd1,
        ST2  = 3'd2,
        ST3  = 3'd3,
        DONE = 3'd4
    } state_t;

    // W8^k in Q2.14, element k
    localparam logic [3:0][DW-1:0] C_TW_RE = {-16'sd11585, 16'sd0,      16'sd11585, 16'sd16384};
    localparam logic [3:0][DW-1:0] C_TW_IM = {-16'sd11585, -16'sd16384, -16'sd11585, 16'sd0};

    function automatic logic [2:0] bitrev3(input logic [2:0] n);
        return {n[0], n[1], n[2]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_butterfly.sv
`default_nettype none
// ============================================================================
// Module   : fft_butterfly
// Brief    : Combinational radix-2 DIT butterfly, t = W*b, a' = a+t, b' = a-t.
// Revision : 1.0
// ============================================================================
module fft_butterfly #(
    parameter int DW      = 16,
    parameter int TW_FRAC = 14
) (
    input  logic signed [DW-1:0] a_re,
    input  logic signed [DW-1:0] a_im,
    input  logic signed [DW-1:0] b_re,
    input  logic signed [DW-1:0] b_im,
    input  logic signed [DW-1:0] w_re,
    input  logic signed [DW-1:0] w_im,
    output logic signed [DW-1:0] ap_re,
    output logic signed [DW-1:0] ap_im,
    output logic signed [DW-1:0] bp_re,
    output logic signed [DW-1:0] bp_im
);

    localparam int PW = 2*DW + 1;

    logic signed [PW-1:0] w_prod_re;
    logic signed [PW-1:0] w_prod_im;
    logic signed [DW-1:0] w_t_re;
    logic signed [DW-1:0] w_t_im;

    always_comb begin
        w_prod_re = PW'(w_re) * PW'(b_re) - PW'(w_im) * PW'(b_im);
        w_prod_im = PW'(w_re) * PW'(b_im) + PW'(w_im) * PW'(b_re);
        // Truncating shift back to Q8.8; sums wrap in DW bits
        w_t_re    = DW'(w_prod_re >>> TW_FRAC);
        w_t_im    = DW'(w_prod_im >>> TW_FRAC);
        ap_re     = a_re + w_t_re;
        ap_im     = a_im + w_t_im;
        bp_re     = a_re - w_t_re;
        bp_im     = a_im - w_t_im;
    end

endmodule
`default_nettype wire

// File: rtl/fft_top_module.sv
`default_nettype none
// ============================================================================
// Module   : fft_top_module
// Brief    : Runs one 8-point FFT on a ROM after reset; a push switch pages
//            through the 16 result words shown on the LEDs.
// Revision : 1.0
// ============================================================================
module fft_top_module
    import fft_pkg::*;
#(
    parameter logic [63:0] SAMPLES = 64'h00000000_01010101,
    parameter int          TW_FRAC = 14
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          switch,
    output logic [DW-1:0] array
);

    state_t              r_state;
    state_t              w_state_nx;
    logic [7:0][DW-1:0]  r_re;
    logic [7:0][DW-1:0]  r_im;
    logic [1:0]          r_bf;
    logic [2:0]          r_sync;
    logic [3:0]          r_index;

    logic [2:0]          w_ia;
    logic [2:0]          w_ib;
    logic [1:0]          w_k;
    logic                w_rise;
    logic signed [DW-1:0] w_ap_re, w_ap_im, w_bp_re, w_bp_im;

    // Butterfly j of each stage: span 1/2/4, a = group*2*span + pos, b = a + span
    always_comb begin
        w_state_nx = r_state;
        w_ia       = 3'd0;
        w_ib       = 3'd0;
        w_k        = 2'd0;
        case (r_state)
            LOAD: w_state_nx = ST1;
            ST1: begin
                w_ia = {r_bf, 1'b0};
                w_ib = {r_bf, 1'b1};
                if (r_bf == 2'd3) w_state_nx = ST2;
            end
            ST2: begin
                w_ia = {r_bf[1], 1'b0, r_bf[0]};
                w_ib = {r_bf[1], 1'b1, r_bf[0]};
                w_k  = {r_bf[0], 1'b0};
                if (r_bf == 2'd3) w_state_nx = ST3;
            end
            ST3: begin
                w_ia = {1'b0, r_bf};
                w_ib = {1'b1, r_bf};
                w_k  = r_bf;
                if (r_bf == 2'd3) w_state_nx = DONE;
            end
            default: w_state_nx = DONE;
        endcase
    end

    fft_butterfly #(.DW(DW), .TW_FRAC(TW_FRAC)) u_bfly (
        .a_re  ($signed(r_re[w_ia])),
        .a_im  ($signed(r_im[w_ia])),
        .b_re  ($signed(r_re[w_ib])),
        .b_im  ($signed(r_im[w_ib])),
        .w_re  ($signed(C_TW_RE[w_k])),
        .w_im  ($signed(C_TW_IM[w_k])),
        .ap_re (w_ap_re),
        .ap_im (w_ap_im),
        .bp_re (w_bp_re),
        .bp_im (w_bp_im)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= LOAD;
            r_bf    <= 2'd0;
            r_re    <= '0;
            r_im    <= '0;
        end else begin
            r_state <= w_state_nx;
            if (r_state == LOAD) begin
                // Q8.8 of a sign-extended byte is just the byte over eight zeros
                for (int n = 0; n < 8; n++) begin
                    r_re[bitrev3(3'(n))] <= {SAMPLES[8*n +: 8], 8'h00};
                    r_im[bitrev3(3'(n))] <= '0;
                end
            end else if (r_state != DONE) begin
                r_bf       <= r_bf + 2'd1;
                r_re[w_ia] <= w_ap_re;
                r_im[w_ia] <= w_ap_im;
                r_re[w_ib] <= w_bp_re;
                r_im[w_ib] <= w_bp_im;
            end
        end
    end

    assign w_rise = r_sync[1] & ~r_sync[2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync  <= 3'b000;
            r_index <= 4'd0;
            array   <= '0;
        end else begin
            r_sync <= {r_sync[1:0], switch};
            if (r_state == DONE) begin
                if (w_rise) r_index <= r_index + 4'd1;
                array <= r_index[0] ? r_im[r_index[3:1]] : r_re[r_index[3:1]];
            end else begin
                array <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_top_module.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_top_module
// Brief    : Random switch/reset stimulus with a scoreboard against an
//            array-based FFT reference, on the default ROM and an impulse ROM.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_fft_top_module;

    localparam logic [63:0] S0 = 64'h00000000_01010101;
    localparam logic [63:0] S1 = 64'h00000000_00000001;

    logic        clk    = 1'b0;
    logic        reset  = 1'b0;
    logic        switch = 1'b0;
    logic [15:0] array0;
    logic [15:0] array1;

    fft_top_module #(.SAMPLES(S0), .TW_FRAC(14)) dut0 (
        .clk(clk), .reset(reset), .switch(switch), .array(array0));
    fft_top_module #(.SAMPLES(S1), .TW_FRAC(14)) dut1 (
        .clk(clk), .reset(reset), .switch(switch), .array(array1));

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          idx   = 0;
    logic [15:0] m_word [2][16];
    logic [15:0] q_e0 [$];
    logic [15:0] q_e1 [$];
    string       q_nm [$];
    event        ev_chk;

    function automatic longint wrap16(input longint v);
        logic [15:0] t;
        t = v[15:0];
        return longint'($signed(t));
    endfunction

    // Textbook iterative DIT FFT over plain arrays
    task automatic build_model(input logic [63:0] s, input int w);
        longint re [8];
        longint im [8];
        longint wr [4] = '{16384, 11585, 0, -11585};
        longint wi [4] = '{0, -11585, -16384, -11585};
        for (int n = 0; n < 8; n++) begin
            int          r;
            logic [7:0]  b;
            r     = ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
            b     = s[8*n +: 8];
            re[r] = longint'($signed(b)) * 256;
            im[r] = 0;
        end
        for (int span = 1; span < 8; span *= 2) begin
            for (int g = 0; g < 8; g += 2*span) begin
                for (int p = 0; p < span; p++) begin
                    int     a, bb, k;
                    longint tr, ti, ar, ai;
                    a  = g + p;
                    bb = a + span;
                    k  = p * (4 / span);
                    tr = (wr[k]*re[bb] - wi[k]*im[bb]) >>> 14;
                    ti = (wr[k]*im[bb] + wi[k]*re[bb]) >>> 14;
                    ar = re[a];
                    ai = im[a];
                    re[a]  = wrap16(ar + tr);
                    im[a]  = wrap16(ai + ti);
                    re[bb] = wrap16(ar - tr);
                    im[bb] = wrap16(ai - ti);
                end
            end
        end
        for (int k = 0; k < 8; k++) begin
            m_word[w][2*k]   = re[k][15:0];
            m_word[w][2*k+1] = im[k][15:0];
        end
    endtask

    task automatic expect_val(input string nm, input logic [15:0] e0, input logic [15:0] e1);
        q_e0.push_back(e0);
        q_e1.push_back(e1);
        q_nm.push_back(nm);
        -> ev_chk;
    endtask

    task automatic expect_idx(input string nm);
        expect_val(nm, m_word[0][idx], m_word[1][idx]);
    endtask

    initial begin : monitor
        logic [15:0] e0, e1;
        string       nm;
        forever begin
            @(ev_chk);
            while (q_e0.size() > 0) begin
                e0 = q_e0.pop_front();
                e1 = q_e1.pop_front();
                nm = q_nm.pop_front();
                n_cmp++;
                if (array0 !== e0) begin
                    n_bad++;
                    $display("FAIL %s rom0 idx=%0d: got %h want %h", nm, idx, array0, e0);
                end
                n_cmp++;
                if (array1 !== e1) begin
                    n_bad++;
                    $display("FAIL %s impulse idx=%0d: got %h want %h", nm, idx, array1, e1);
                end
            end
        end
    end

    task automatic press(input bit chk);
        switch = 1'b1;
        repeat ($urandom_range(2, 5)) @(negedge clk);
        switch = 1'b0;
        repeat ($urandom_range(2, 5)) @(negedge clk);
        idx = (idx + 1) % 16;
        if (chk) begin
            repeat (3) @(negedge clk);
            expect_idx($sformatf("press_to_%0d", idx));
        end
    endtask

    task automatic reset_and_recompute(input bit async_mid);
        if (async_mid) begin
            @(posedge clk);
            #($urandom_range(1, 4));
            reset = 1'b0;
            #1;
            expect_val("async_reset", 16'h0000, 16'h0000);
            @(negedge clk);
            @(negedge clk);
        end
        switch = 1'b0;
        reset  = 1'b1;
        idx    = 0;
        // Early presses land before DONE and must leave the index alone
        for (int c = 0; c < 10; c++) begin
            switch = async_mid ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
        end
        switch = 1'b0;
        expect_val("before_done", 16'h0000, 16'h0000);
        repeat (10) @(negedge clk);
        expect_idx("after_release");
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : stimulus
        build_model(S0, 0);
        build_model(S1, 1);
        repeat (3) @(negedge clk);
        expect_val("reset_state", 16'h0000, 16'h0000);
        reset_and_recompute(1'b0);

        // Directed walk of the first words of X0/X1
        for (int i = 0; i < 3; i++) press(1'b1);

        for (int it = 0; it < 70; it++) begin
            if ($urandom_range(0, 9) == 0) reset_and_recompute(1'b1);
            else                           press(1'b1);
        end

        // Sixteen presses come back to the same word
        for (int i = 0; i < 16; i++) press(1'b0);
        repeat (3) @(negedge clk);
        expect_idx("wrap_16");

        // Hold the switch high for a long time: exactly one step
        switch = 1'b1;
        repeat (20) @(negedge clk);
        switch = 1'b0;
        idx = (idx + 1) % 16;
        repeat (4) @(negedge clk);
        expect_idx("held_high");

        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
